// File: rtl/param_fifo.sv
// param_fifo: single-clock synchronous FIFO with registered read data,
// count-decoded status flags and one-cycle overflow/underflow pulses.
module param_fifo #(
  parameter int DATA_WIDTH    = 4,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         read_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flags come only from the registered count, never from the request inputs.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AFULL_THRESH));
  assign almost_empty = (count <= CNT_W'(AEMPTY_THRESH));

  // A write into a full FIFO is still taken when a read frees a slot on the same edge;
  // a read from an empty FIFO is never taken (no write-to-read bypass).
  assign wr_ok = write_en & (~full | read_en);
  assign rd_ok = read_en & ~empty;

  // Storage array: written on accepted writes only, never reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally because they are exactly PTR_W bits wide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy counter: moves only when exactly one side is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered read data: loads on an accepted read, otherwise holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem[rd_ptr];
    end
  end

  // Error pulses for rejected requests, visible for the cycle after the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write_en & full & ~read_en;
      underflow <= read_en & empty;
    end
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width of each stored word, minimum 1.
REQ-002 Parameter DEPTH, default 8: number of storage entries, power of two, minimum 2.
REQ-003 Parameter AFULL_THRESH, default DEPTH-2: almost_full asserts when count >= AFULL_THRESH, range 1..DEPTH.
REQ-004 Parameter AEMPTY_THRESH, default 2: almost_empty asserts when count <= AEMPTY_THRESH, range 0..DEPTH-1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; the block is reset on a rising clk edge while reset=0.
REQ-007 write_en  input  1  write request.
REQ-008 data_in  input  DATA_WIDTH  write data, sampled on the rising edge where the write is accepted.
REQ-009 read_en  input  1  read request.
REQ-010 data_out  output  DATA_WIDTH  registered read data.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 almost_full  output  1  count >= AFULL_THRESH.
REQ-014 almost_empty  output  1  count <= AEMPTY_THRESH.
REQ-015 count  output  clog2(DEPTH)+1  number of stored words, range 0..DEPTH.
REQ-016 overflow  output  1  one-cycle pulse for a rejected write.
REQ-017 underflow  output  1  one-cycle pulse for a rejected read.

Function
REQ-018 Storage is DEPTH x DATA_WIDTH; read and write pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without any special-case logic.
REQ-019 Write acceptance: write_en=1 and (full=0 or read_en=1); an accepted write stores data_in at the write pointer and advances the write pointer by 1.
REQ-020 Read acceptance: read_en=1 and empty=0; an accepted read loads mem[read pointer] into data_out and advances the read pointer by 1.
REQ-021 Read latency is exactly one cycle: data_out shows the word on the rising edge that accepts the read, and data_out holds its value in every cycle with no accepted read.
REQ-022 Full with write_en=1 and read_en=1: both operations are accepted; count stays at DEPTH; data_out receives the oldest word; overflow stays 0.
REQ-023 Empty with write_en=1 and read_en=1: only the write is accepted; count becomes 1; data_out is unchanged; underflow pulses 1. There is no write-to-read bypass.
REQ-024 count next-state: +1 for an accepted write only; -1 for an accepted read only; unchanged when both or neither are accepted. count never leaves 0..DEPTH.
REQ-025 full, empty, almost_full and almost_empty are decoded combinationally from the registered count only; none of them depends combinationally on any input.
REQ-026 overflow is registered and equals 1 for the one cycle after an edge where write_en=1, full=1 and read_en=0; the FIFO state is unchanged by the rejected write.
REQ-027 underflow is registered and equals 1 for the one cycle after an edge where read_en=1 and empty=1; the FIFO state and data_out are unchanged by the rejected read.
REQ-028 Words are read out in exactly the order they were written, across any number of pointer wraps.

Reset
REQ-029 On a rising clk edge with reset=0: both pointers = 0, count = 0, data_out = 0, overflow = 0, underflow = 0; therefore empty=1, full=0, almost_empty=1 and almost_full=0 (for the default thresholds).
REQ-030 Reset has priority over read_en and write_en in the same cycle; a reset in the middle of operation discards all stored words.
REQ-031 Memory contents are not reset; the design never reads them before they have been written.

Verification
REQ-032 Defaults; write 8 words 1..8 -> full=1 and count=8 after the 8th edge; almost_full first asserts at count=6; a 9th write gives an overflow pulse and count stays 8.
REQ-033 From full, read 8 times -> data_out shows 1..8 in order, one per cycle; empty=1 after the last read; a 9th read gives an underflow pulse and data_out holds 8.
REQ-034 Full FIFO, simultaneous read+write for 20 cycles with data_in 0..F repeating -> count stays 8, there is no overflow, and the output order matches the input order across the wraps.
REQ-035 Empty FIFO, simultaneous read+write of 0xA -> count=1, data_out unchanged, underflow=1 for 1 cycle; a read on the next cycle gives data_out=0xA.
REQ-036 Write 5 words, then reset=0 for one edge together with write_en=1 -> count=0, empty=1, data_out=0, and no word is stored.
REQ-037 Repeat REQ-032 to REQ-035 with DATA_WIDTH=16, DEPTH=32 and the thresholds at 1 and DEPTH-1 -> all flags match a reference count model every cycle.
